// File: rtl/queue_burst_reader_if.sv
// Handshake bundle for queue_burst_reader: start/status, queue read side and
// downstream word stream. The slave modport is the reader itself; the master
// modport is whatever drives it (controller, queue model, sink).
interface queue_burst_reader_if #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 5
);
   logic             start;
   logic [LEN_W-1:0] burst_len;
   logic             busy;
   logic             done;
   logic             q_empty;
   logic             q_dequeue;
   logic [WIDTH-1:0] q_data;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport slave (
      input  start, burst_len, q_empty, q_data, out_ready,
      output busy, done, q_dequeue, out_data, out_valid
   );

   modport master (
      output start, burst_len, q_empty, q_data, out_ready,
      input  busy, done, q_dequeue, out_data, out_valid
   );
endinterface

// File: rtl/queue_burst_reader.sv
// Burst reader: pops burst_len words from a one-cycle-latency queue and
// streams them downstream through a 2-entry buffer with valid/ready flow
// control. Pops are throttled so buffered plus in-flight words never exceed
// two, which sustains one word per cycle without overflowing the buffer.
module queue_burst_reader #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 5
) (
   input logic                 clk,
   input logic                 rst,
   queue_burst_reader_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [LEN_W-1:0] r_issue_cnt;
   logic [LEN_W-1:0] r_deliver_cnt;
   logic [WIDTH-1:0] r_buf [2];
   logic [1:0]       r_occ;
   logic             r_inflight;

   logic             w_start_ok;
   logic             w_leave;
   logic             w_deq;
   logic [1:0]       w_fill;
   logic [1:0]       w_occ_after;
   logic [WIDTH-1:0] w_buf0_nxt;
   logic [WIDTH-1:0] w_buf1_nxt;

   assign w_start_ok = (r_state == IDLE) && bus.start;
   assign w_leave    = (r_occ != 2'd0) && bus.out_ready;
   // Words that will sit in the buffer after this edge, before any new pop.
   assign w_fill      = r_occ + {1'b0, r_inflight} - {1'b0, w_leave};
   assign w_occ_after = r_occ - {1'b0, w_leave};

   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = (r_state == FIN);
   assign bus.q_dequeue = w_deq;
   assign bus.out_valid = (r_occ != 2'd0);
   assign bus.out_data  = r_buf[0];

   // State register.
   // NOTE: every clocked process assigns with <= so all registers sample the
   // pre-edge values of each other, independent of process evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state decode and queue pop strobe.
   // NOTE: defaults come first so that no path leaves an output unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_deq       = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (bus.start) w_state_nxt = (bus.burst_len != '0) ? RUN : FIN;
         end
         RUN: begin
            w_deq = !bus.q_empty && (r_issue_cnt != '0) && (w_fill < 2'd2);
            if (w_leave && (r_deliver_cnt == LEN_W'(1))) w_state_nxt = FIN;
         end
         FIN:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Issue/deliver counters: loaded on accepted start, otherwise decremented
   // per pop and per downstream transfer, saturating at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_issue_cnt   <= '0;
         r_deliver_cnt <= '0;
      end else if (w_start_ok) begin
         r_issue_cnt   <= bus.burst_len;
         r_deliver_cnt <= bus.burst_len;
      end else begin
         if (w_deq && (r_issue_cnt != '0))       r_issue_cnt   <= r_issue_cnt - 1'b1;
         if (w_leave && (r_deliver_cnt != '0))   r_deliver_cnt <= r_deliver_cnt - 1'b1;
      end
   end

   // Buffer update: head shifts out on transfer, the arriving word lands in
   // the first free slot after the shift so order is preserved.
   always_comb begin
      w_buf0_nxt = w_leave ? r_buf[1] : r_buf[0];
      w_buf1_nxt = r_buf[1];
      if (r_inflight) begin
         if (w_occ_after == 2'd0) w_buf0_nxt = bus.q_data;
         else                     w_buf1_nxt = bus.q_data;
      end
   end

   // Buffer storage, occupancy and in-flight read tracking.
   // NOTE: the two buffer words are reset because out_data is required to
   // read zero during reset; a deeper storage array would normally be left
   // unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_buf[0]   <= '0;
         r_buf[1]   <= '0;
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
      end else begin
         r_buf[0]   <= w_buf0_nxt;
         r_buf[1]   <= w_buf1_nxt;
         r_occ      <= w_occ_after + {1'b0, r_inflight};
         r_inflight <= w_deq;
      end
   end

endmodule

// File: tb/tb_queue_burst_reader.sv
// Bench for queue_burst_reader: a queue model with one-cycle read latency,
// a sink monitor collecting transferred words, and directed plus random
// bursts. Expected words for a burst are the next len entries of the queue
// memory at the time the burst starts.
module tb_queue_burst_reader;

   localparam int WIDTH = 8;
   localparam int LEN_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;

   queue_burst_reader_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

   queue_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] mem [256];
   int               wr_ptr = 0;
   int               rd_ptr = 0;
   logic [WIDTH-1:0] got [$];
   int               pops = 0;
   logic             hold = 1'b0;
   logic [WIDTH-1:0] held = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   assign bus.q_empty = (rd_ptr == wr_ptr);

   // Queue read side: word popped in cycle t appears on q_data in cycle t+1.
   always @(posedge clk) begin
      if (rst && bus.q_dequeue) begin
         bus.q_data <= mem[rd_ptr[7:0]];
         rd_ptr     <= rd_ptr + 1;
      end
   end

   // Sink monitor: collects transfers, counts pops, checks hold stability.
   always @(posedge clk) begin
      if (!rst) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", 32'(bus.out_data), 32'(held));
         end
         if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
         if (bus.q_dequeue) begin
            pops++;
            chk("pop_not_empty", 32'(bus.q_empty), 32'd0);
         end
         hold = bus.out_valid && !bus.out_ready;
         held = bus.out_data;
      end
   end

   task automatic push(input logic [WIDTH-1:0] v);
      mem[wr_ptr[7:0]] = v;
      wr_ptr++;
   endtask

   // Presents start for one cycle; returns at the negedge of the first cycle
   // after the accepting edge.
   task automatic start_burst(input int len);
      @(negedge clk);
      got.delete();
      pops          = 0;
      bus.start     = 1'b1;
      bus.burst_len = LEN_W'(len);
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   // Waits for done with a cycle budget; optionally randomizes out_ready and
   // trickles the remaining words into the queue.
   task automatic wait_done(input string tag, input int budget, input bit rnd, inout int to_push);
      bit seen = 1'b0;
      for (int c = 0; c < budget && !seen; c++) begin
         if (bus.done) seen = 1'b1;
         else begin
            @(negedge clk);
            if (rnd) begin
               bus.out_ready = ($urandom_range(0, 3) != 0);
               if (to_push > 0 && $urandom_range(0, 1) == 1) begin
                  push(WIDTH'($urandom));
                  to_push--;
               end
            end
         end
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic chk_words(input string tag, input int base, input int len);
      chk({tag, "_count"}, 32'(got.size()), 32'(len));
      for (int i = 0; i < len && i < got.size(); i++)
         chk({tag, "_word"}, 32'(got[i]), 32'(mem[(base + i) % 256]));
   endtask

   initial begin
      int base;
      int none;
      bit exp_deq [7];
      bit exp_val [7];
      bit exp_done[7];
      bit exp_busy[7];
      none          = 0;
      bus.start     = 1'b0;
      bus.burst_len = '0;
      bus.out_ready = 1'b0;

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_deq", 32'(bus.q_dequeue), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data", 32'(bus.out_data), 32'd0);
      rst = 1'b1;

      // Basic burst of three with the sink always ready.
      push(8'h55); push(8'h56); push(8'h57);
      bus.out_ready = 1'b1;
      base = rd_ptr;
      exp_deq  = '{1, 1, 1, 0, 0, 0, 0};
      exp_val  = '{0, 0, 1, 1, 1, 0, 0};
      exp_done = '{0, 0, 0, 0, 0, 1, 0};
      exp_busy = '{1, 1, 1, 1, 1, 1, 0};
      start_burst(3);
      for (int c = 0; c < 7; c++) begin
         chk($sformatf("basic_deq_c%0d", c + 1), 32'(bus.q_dequeue), 32'(exp_deq[c]));
         chk($sformatf("basic_valid_c%0d", c + 1), 32'(bus.out_valid), 32'(exp_val[c]));
         chk($sformatf("basic_done_c%0d", c + 1), 32'(bus.done), 32'(exp_done[c]));
         chk($sformatf("basic_busy_c%0d", c + 1), 32'(bus.busy), 32'(exp_busy[c]));
         if (exp_val[c])
            chk($sformatf("basic_data_c%0d", c + 1), 32'(bus.out_data), 32'(8'h55 + c - 2));
         @(negedge clk);
      end
      chk_words("basic", base, 3);

      // Backpressure: sink stalled for five cycles, then released.
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
      bus.out_ready = 1'b0;
      base = rd_ptr;
      start_burst(4);
      for (int c = 1; c <= 5; c++) begin
         if (c >= 3) begin
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_frozen", 32'(bus.out_data), 32'(mem[base % 256]));
         end
         if (c < 5) @(negedge clk);
      end
      chk("bp_pops", 32'(pops), 32'd2);
      bus.out_ready = 1'b1;
      wait_done("bp", 50, 1'b0, none);
      chk_words("bp", base, 4);
      chk("bp_total_pops", 32'(pops), 32'd4);

      // Starvation: one word present, two more arrive later.
      push(8'hC1);
      base = rd_ptr;
      start_burst(3);
      repeat (5) @(negedge clk);
      chk("starve_pops", 32'(pops), 32'd1);
      chk("starve_busy", 32'(bus.busy), 32'd1);
      chk("starve_got", 32'(got.size()), 32'd1);
      push(8'hC2); push(8'hC3);
      wait_done("starve", 50, 1'b0, none);
      chk_words("starve", base, 3);

      // Zero length: done in the cycle after the one carrying start, no pops.
      push(8'hD0);
      start_burst(0);
      chk("zero_done_c1", 32'(bus.done), 32'd1);
      chk("zero_valid_c1", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk("zero_done_c2", 32'(bus.done), 32'd0);
      chk("zero_busy_c2", 32'(bus.busy), 32'd0);
      chk("zero_pops", 32'(pops), 32'd0);

      // Start pulsed mid-burst with a larger length must not reload counters.
      for (int i = 0; i < 6; i++) push(8'hE0 + 8'(i));
      base = rd_ptr;
      start_burst(2);
      bus.start     = 1'b1;
      bus.burst_len = LEN_W'(7);
      @(negedge clk);
      bus.start     = 1'b0;
      wait_done("ign", 50, 1'b0, none);
      @(negedge clk);
      chk_words("ign", base, 2);
      chk("ign_pops", 32'(pops), 32'd2);

      // Asynchronous reset between edges mid-burst.
      base = rd_ptr;
      start_burst(6);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_deq", 32'(bus.q_dequeue), 32'd0);
      chk("arst_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_data", 32'(bus.out_data), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) push(8'hF0 + 8'(i));
      base = rd_ptr;
      start_burst(2);
      wait_done("arst", 50, 1'b0, none);
      @(negedge clk);
      chk_words("arst", base, 2);
      chk("arst_pops", 32'(pops), 32'd2);

      // Random bursts: random lengths, word arrival and sink readiness.
      for (int b = 0; b < 15; b++) begin
         int len;
         int to_push;
         len     = $urandom_range(0, 8);
         to_push = len;
         base    = rd_ptr;
         start_burst(len);
         wait_done($sformatf("rnd%0d", b), 300, 1'b1, to_push);
         bus.out_ready = 1'b1;
         @(negedge clk);
         chk_words($sformatf("rnd%0d", b), base, len);
         chk($sformatf("rnd%0d_pops", b), 32'(pops), 32'(len));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
